// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Requester ids double as round-robin pointer values.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } requester_t;

  // An address is in range when every bit above the memory index is zero.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned mem_addr_bits);
    logic [63:0] upper_mask;
    if (mem_addr_bits >= 32'd64) begin
      upper_mask = 64'd0;
    end else begin
      upper_mask = ~64'd0 << mem_addr_bits;
    end
    return (addr & upper_mask) == 64'd0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// On a tie the requester that was not served last wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // Pick a winner from the current request vector and last-served pointer.
  always_comb begin
    any = req[0] | req[1];
    if (req[0] && req[1]) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = REQ_DBG;
    end else begin
      winner = REQ_CORE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core load/store path and a debug port.
// One access at a time: grant, memory strobe, response on three consecutive cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned MEM_ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [ADDR_WIDTH-1:0]    core_addr,
  input  logic [DATA_WIDTH-1:0]    core_wdata,
  output logic                     core_gnt,
  output logic                     core_rvalid,
  output logic                     core_err,
  output logic                     core_stall,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDR_WIDTH-1:0]    dbg_addr,
  input  logic [DATA_WIDTH-1:0]    dbg_wdata,
  output logic                     dbg_gnt,
  output logic                     dbg_rvalid,
  output logic                     dbg_err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  logic [1:0]            state_r;
  logic                  last_r;
  logic                  winner_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic [1:0] req_vec_s;
  logic       pick_winner_s;
  logic       pick_any_s;
  logic       addr_ok_s;

  // Requests are masked while reset is asserted so no grant can leak out.
  assign req_vec_s = {dbg_req, core_req} & {2{rst}};
  assign addr_ok_s = in_range(64'(addr_r), MEM_ADDR_BITS);
  assign rdata     = rdata_r;

  rr_pick2 u_pick (
    .req    (req_vec_s),
    .last   (last_r),
    .winner (pick_winner_s),
    .any    (pick_any_s)
  );

  // Arbiter FSM plus latched request, error flag and response data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      last_r   <= REQ_DBG;
      winner_r <= REQ_CORE;
      we_r     <= 1'b0;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r  <= {DATA_WIDTH{1'b0}};
      err_r    <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            state_r  <= ST_ACCESS;
            winner_r <= pick_winner_s;
            if (pick_winner_s == REQ_DBG) begin
              we_r    <= dbg_we;
              addr_r  <= dbg_addr;
              wdata_r <= dbg_wdata;
            end else begin
              we_r    <= core_we;
              addr_r  <= core_addr;
              wdata_r <= core_wdata;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_RESP;
          err_r   <= !addr_ok_s;
          if (addr_ok_s && !we_r) begin
            rdata_r <= mem_rdata;
          end else begin
            rdata_r <= {DATA_WIDTH{1'b0}};
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          last_r  <= winner_r;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant, strobe and response decode; everything is low outside its own state.
  always_comb begin
    core_gnt    = 1'b0;
    dbg_gnt     = 1'b0;
    core_rvalid = 1'b0;
    dbg_rvalid  = 1'b0;
    core_err    = 1'b0;
    dbg_err     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = {MEM_ADDR_BITS{1'b0}};
    mem_wdata   = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          core_gnt = (pick_winner_s == REQ_CORE);
          dbg_gnt  = (pick_winner_s == REQ_DBG);
        end else begin
          core_gnt = 1'b0;
          dbg_gnt  = 1'b0;
        end
      end
      ST_ACCESS: begin
        mem_wdata = wdata_r;
        if (addr_ok_s) begin
          mem_addr  = addr_r[MEM_ADDR_BITS-1:0];
          mem_read  = !we_r;
          mem_write = we_r;
        end else begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
      end
      ST_RESP: begin
        core_rvalid = (winner_r == REQ_CORE);
        dbg_rvalid  = (winner_r == REQ_DBG);
        core_err    = (winner_r == REQ_CORE) && err_r;
        dbg_err     = (winner_r == REQ_DBG) && err_r;
      end
      default: begin
        core_gnt = 1'b0;
      end
    endcase
  end

  // The core is released only in its own response cycle.
  always_comb begin
    if (rst && core_req) begin
      core_stall = !((state_r == ST_RESP) && (winner_r == REQ_CORE));
    end else begin
      core_stall = 1'b0;
    end
  end

endmodule
